// File: rtl/vid_cfg_writer.sv
// rtl/vid_cfg_writer.sv - bus initiator that programs the video controller register file
//
// Purpose: on start, acquires the bus through the arbiter and issues seven
// single-beat register writes (H1, H2, V1, V2, base, line increment, CR last),
// waiting for the controller's write response after each one.
//
// Ports:
//   clk          - single clock, all logic on posedge
//   reset        - synchronous, active-low
//   start        - one-cycle request, sampled only while idle
//   *_val        - 32-bit register images, captured on an accepted start
//   ackin        - arbiter grant (looked at only while requesting)
//   cmdin        - response command from the controller, 3'b101 = write response
//   reqout       - arbiter bid, 2'b11 while requesting
//   selout       - bus select during the address and data beats
//   cmdout       - 3'b100 on the address beat, 3'b000 otherwise
//   lenout       - burst length, always single beat
//   addrdataout  - address on the address beat, data on the data beat, else 0
//   busy         - high whenever the sequencer is not idle
//   done         - one-cycle pulse once all seven writes have completed
//   error        - sticky timeout flag, cleared by the next accepted start
//
// Build option: VID_CFG_TIMEOUT_EN adds a WAIT-state watchdog that aborts the
// sequence after TIMEOUT_CYCLES cycles without a response.

module vid_cfg_writer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] cr_val,
   input  logic [31:0] h1_val,
   input  logic [31:0] h2_val,
   input  logic [31:0] v1_val,
   input  logic [31:0] v2_val,
   input  logic [31:0] base_val,
   input  logic [31:0] lineinc_val,
   input  logic        ackin,
   input  logic [2:0]  cmdin,
   output logic [1:0]  reqout,
   output logic        selout,
   output logic [2:0]  cmdout,
   output logic [1:0]  lenout,
   output logic [31:0] addrdataout,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ADDR,
      S_DATA,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [2:0] CMD_WRITE = 3'b100;
   localparam logic [2:0] CMD_WRESP = 3'b101;
   localparam logic [2:0] LAST_IDX  = 3'd6;

   // The WAIT counter is 8 bits wide, so the limit must fit in it.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in the range 1..256");
   end

   state_t      state, state_n;
   logic [2:0]  idx, idx_n;
   logic        err, err_n;
   logic        capture;
   logic        timeout;

   logic [31:0] h1_r, h2_r, v1_r, v2_r, base_r, lineinc_r, cr_r;
   logic [31:0] wr_addr, wr_data;

   logic [1:0]  reqout_n;
   logic        selout_n;
   logic [2:0]  cmdout_n;
   logic [31:0] addrdataout_n;
   logic        busy_n, done_n;

`ifdef VID_CFG_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // Held at zero outside WAIT, so it reads 0 in the first WAIT cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (state != S_WAIT) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign timeout = (state == S_WAIT) && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
   assign error   = err;
`else
   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   assign lenout = 2'b00;

   // Write table. idx only changes on edges into REQ, so it is stable on the
   // edges into ADDR and DATA where these values get registered.
   always_comb begin
      wr_addr = 32'h0;
      wr_data = 32'h0;
      case (idx)
         3'd0: begin wr_addr = 32'h28; wr_data = h1_r;      end
         3'd1: begin wr_addr = 32'h30; wr_data = h2_r;      end
         3'd2: begin wr_addr = 32'h38; wr_data = v1_r;      end
         3'd3: begin wr_addr = 32'h40; wr_data = v2_r;      end
         3'd4: begin wr_addr = 32'h48; wr_data = base_r;    end
         3'd5: begin wr_addr = 32'h50; wr_data = lineinc_r; end
         3'd6: begin wr_addr = 32'h00; wr_data = cr_r;      end
         default: ;
      endcase
   end

   // Next state plus output decode of the next state; outputs are registered
   // so they line up with the state they describe.
   always_comb begin
      state_n  = state;
      idx_n    = idx;
      err_n    = err;
      capture  = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_REQ;
               idx_n   = 3'd0;
               err_n   = 1'b0;
               capture = 1'b1;
            end
         end
         S_REQ: begin
            if (ackin) state_n = S_ADDR;
         end
         S_ADDR: state_n = S_DATA;
         S_DATA: state_n = S_WAIT;
         S_WAIT: begin
            if (cmdin == CMD_WRESP) begin
               if (idx == LAST_IDX) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_REQ;
                  idx_n   = idx + 3'd1;
               end
            end else if (timeout) begin
               state_n = S_IDLE;
               err_n   = 1'b1;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      reqout_n      = 2'b00;
      selout_n      = 1'b0;
      cmdout_n      = 3'b000;
      addrdataout_n = 32'h0;
      busy_n        = (state_n != S_IDLE);
      done_n        = (state_n == S_DONE);

      case (state_n)
         S_REQ:  reqout_n = 2'b11;
         S_ADDR: begin
            selout_n      = 1'b1;
            cmdout_n      = CMD_WRITE;
            addrdataout_n = wr_addr;
         end
         S_DATA: begin
            selout_n      = 1'b1;
            addrdataout_n = wr_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         idx         <= 3'd0;
         err         <= 1'b0;
         reqout      <= 2'b00;
         selout      <= 1'b0;
         cmdout      <= 3'b000;
         addrdataout <= 32'h0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         err         <= err_n;
         reqout      <= reqout_n;
         selout      <= selout_n;
         cmdout      <= cmdout_n;
         addrdataout <= addrdataout_n;
         busy        <= busy_n;
         done        <= done_n;
      end
   end

   // Register images are frozen for the whole sequence.
   always_ff @(posedge clk) begin
      if (!reset) begin
         h1_r      <= 32'h0;
         h2_r      <= 32'h0;
         v1_r      <= 32'h0;
         v2_r      <= 32'h0;
         base_r    <= 32'h0;
         lineinc_r <= 32'h0;
         cr_r      <= 32'h0;
      end else if (capture) begin
         h1_r      <= h1_val;
         h2_r      <= h2_val;
         v1_r      <= v1_val;
         v2_r      <= v2_val;
         base_r    <= base_val;
         lineinc_r <= lineinc_val;
         cr_r      <= cr_val;
      end
   end

endmodule

// File: tb/tb_vid_cfg_writer.sv
// tb/tb_vid_cfg_writer.sv - directed self-checking bench for vid_cfg_writer
//
// Purpose: drives scenario records through the write sequence and compares
// every bus beat and status output against hand-computed expectations.
// Ports: none (top-level bench). Honours VID_CFG_TIMEOUT_EN like the design.

module tb_vid_cfg_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] cr_val, h1_val, h2_val, v1_val, v2_val, base_val, lineinc_val;
   logic        ackin;
   logic [2:0]  cmdin;
   logic [1:0]  reqout;
   logic        selout;
   logic [2:0]  cmdout;
   logic [1:0]  lenout;
   logic [31:0] addrdataout;
   logic        busy;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] exp_addr [7];
   logic [31:0] exp_data [7];

   typedef struct {
      int          stall_idx;
      int          stall_len;
      int          resp_idx;
      int          resp_len;
      bit          stray;
      logic [31:0] h1;
      logic [31:0] cr;
      int          exp_done;
   } scen_t;

   scen_t tbl [$];
   scen_t nominal;

   vid_cfg_writer #(.TIMEOUT_CYCLES(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cr_val      (cr_val),
      .h1_val      (h1_val),
      .h2_val      (h2_val),
      .v1_val      (v1_val),
      .v2_val      (v2_val),
      .base_val    (base_val),
      .lineinc_val (lineinc_val),
      .ackin       (ackin),
      .cmdin       (cmdin),
      .reqout      (reqout),
      .selout      (selout),
      .cmdout      (cmdout),
      .lenout      (lenout),
      .addrdataout (addrdataout),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic load_values(input scen_t s);
      h1_val      = s.h1;
      h2_val      = 32'h0A00_0340;
      v1_val      = 32'h0200_01E0;
      v2_val      = 32'h0200_01F0;
      base_val    = 32'h8000_1000;
      lineinc_val = 32'h0000_0A00;
      cr_val      = s.cr;
      exp_data[0] = s.h1;
      exp_data[1] = 32'h0A00_0340;
      exp_data[2] = 32'h0200_01E0;
      exp_data[3] = 32'h0200_01F0;
      exp_data[4] = 32'h8000_1000;
      exp_data[5] = 32'h0000_0A00;
      exp_data[6] = s.cr;
   endtask

   task automatic start_seq();
      start = 1'b1;
      @(negedge clk);
      cyc   = 1;
      start = 1'b0;
   endtask

   // Entered at the first REQ cycle of write k; leaves at the cycle after WAIT.
   task automatic run_write(input int k, input int ack_d, input int resp_d, input bit stray);
      for (int i = 0; i <= ack_d; i++) begin
         chk($sformatf("w%0d req reqout", k), 32'(reqout), 32'h3);
         chk($sformatf("w%0d req selout", k), 32'(selout), 32'h0);
         chk($sformatf("w%0d req busy", k), 32'(busy), 32'h1);
         ackin = (i == ack_d);
         cmdin = stray ? 3'b101 : 3'b000;
         step();
      end
      ackin = 1'b0;
      chk($sformatf("w%0d addr reqout", k), 32'(reqout), 32'h0);
      chk($sformatf("w%0d addr selout", k), 32'(selout), 32'h1);
      chk($sformatf("w%0d addr cmdout", k), 32'(cmdout), 32'h4);
      chk($sformatf("w%0d addr lenout", k), 32'(lenout), 32'h0);
      chk($sformatf("w%0d addr value", k), addrdataout, exp_addr[k]);
      cmdin = stray ? 3'b101 : 3'b000;
      step();
      chk($sformatf("w%0d data selout", k), 32'(selout), 32'h1);
      chk($sformatf("w%0d data cmdout", k), 32'(cmdout), 32'h0);
      chk($sformatf("w%0d data value", k), addrdataout, exp_data[k]);
      cmdin = 3'b000;
      start = stray;
      step();
      start = 1'b0;
      for (int j = 0; j <= resp_d; j++) begin
         chk($sformatf("w%0d wait selout", k), 32'(selout), 32'h0);
         chk($sformatf("w%0d wait busy", k), 32'(busy), 32'h1);
         chk($sformatf("w%0d wait reqout", k), 32'(reqout), 32'h0);
         chk($sformatf("w%0d wait done", k), 32'(done), 32'h0);
         chk($sformatf("w%0d wait error", k), 32'(error), 32'h0);
         cmdin = (j == resp_d) ? 3'b101 : 3'b000;
         step();
      end
      cmdin = 3'b000;
   endtask

   task automatic run_writes(input scen_t s);
      for (int k = 0; k < 7; k++) begin
         run_write(k, (k == s.stall_idx) ? s.stall_len : 0,
                      (k == s.resp_idx) ? s.resp_len : 0, s.stray);
      end
      chk("done pulse", 32'(done), 32'h1);
      chk("done cycle", 32'(cyc), 32'(s.exp_done));
      chk("done busy", 32'(busy), 32'h1);
      chk("done error", 32'(error), 32'h0);
      step();
      chk("post done", 32'(done), 32'h0);
      chk("post busy", 32'(busy), 32'h0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " reqout"}, 32'(reqout), 32'h0);
      chk({tag, " selout"}, 32'(selout), 32'h0);
      chk({tag, " cmdout"}, 32'(cmdout), 32'h0);
      chk({tag, " lenout"}, 32'(lenout), 32'h0);
      chk({tag, " addrdata"}, addrdataout, 32'h0);
      chk({tag, " busy"}, 32'(busy), 32'h0);
      chk({tag, " done"}, 32'(done), 32'h0);
      chk({tag, " error"}, 32'(error), 32'h0);
   endtask

   initial begin
      exp_addr = '{32'h28, 32'h30, 32'h38, 32'h40, 32'h48, 32'h50, 32'h00};

      nominal = '{stall_idx: -1, stall_len: 0, resp_idx: -1, resp_len: 0, stray: 1'b0,
                  h1: 32'h0A00_0320, cr: 32'h0000_0008, exp_done: 29};
      tbl.push_back(nominal);
      tbl.push_back('{stall_idx: 1, stall_len: 5, resp_idx: -1, resp_len: 0, stray: 1'b0,
                      h1: 32'h1234_5678, cr: 32'h0000_0009, exp_done: 34});
      tbl.push_back('{stall_idx: -1, stall_len: 0, resp_idx: -1, resp_len: 0, stray: 1'b1,
                      h1: 32'hCAFE_0001, cr: 32'h0000_000B, exp_done: 29});
`ifndef VID_CFG_TIMEOUT_EN
      tbl.push_back('{stall_idx: -1, stall_len: 0, resp_idx: 0, resp_len: 200, stray: 1'b0,
                      h1: 32'h0A00_0320, cr: 32'h0000_0008, exp_done: 229});
`endif

      reset = 1'b0;
      start = 1'b0;
      ackin = 1'b0;
      cmdin = 3'b000;
      load_values(nominal);
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      foreach (tbl[n]) begin
         load_values(tbl[n]);
         start_seq();
         run_writes(tbl[n]);
         repeat (2) @(negedge clk);
      end

      // Reset asserted during the data beat of write 3.
      load_values(nominal);
      start_seq();
      run_write(0, 0, 0, 1'b0);
      run_write(1, 0, 0, 1'b0);
      chk("rst w2 reqout", 32'(reqout), 32'h3);
      ackin = 1'b1;
      step();
      ackin = 1'b0;
      chk("rst w2 addr", addrdataout, 32'h38);
      step();
      chk("rst w2 data", addrdataout, exp_data[2]);
      reset = 1'b0;
      step();
      chk_all_zero("midreset");
      reset = 1'b1;
      step();
      chk("idle after reset busy", 32'(busy), 32'h0);
      start_seq();
      run_writes(nominal);

`ifdef VID_CFG_TIMEOUT_EN
      // Write 1 never answered: abort after 64 WAIT cycles.
      load_values(nominal);
      start_seq();
      chk("tmo req", 32'(reqout), 32'h3);
      ackin = 1'b1;
      step();
      ackin = 1'b0;
      chk("tmo addr", addrdataout, 32'h28);
      step();
      step();
      for (int j = 0; j < 64; j++) begin
         chk("tmo wait busy", 32'(busy), 32'h1);
         chk("tmo wait error", 32'(error), 32'h0);
         step();
      end
      chk("tmo error set", 32'(error), 32'h1);
      chk("tmo busy", 32'(busy), 32'h0);
      chk("tmo done", 32'(done), 32'h0);
      for (int j = 0; j < 5; j++) begin
         chk("tmo no bus selout", 32'(selout), 32'h0);
         chk("tmo no done", 32'(done), 32'h0);
         chk("tmo error sticky", 32'(error), 32'h1);
         step();
      end
      start_seq();
      chk("tmo error cleared", 32'(error), 32'h0);
      run_writes(nominal);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
